// File: rtl/da_fir_engine.sv
// Bit-serial distributed-arithmetic FIR with owned delay line and per-group writable partial-sum LUTs.
// Result valid DATA_W+3 cycles after accept; in_ready stays low until the result is consumed.
module da_fir_engine #(
  parameter int DATA_W    = 8,
  parameter int TAPS      = 8,
  parameter int GROUP     = 4,
  parameter int LUT_W     = 20,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 24,
  parameter int OUT_SHIFT = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_W-1:0]                    out_data,
  output logic                                out_sat,
  output logic                                busy,
  input  logic                                lut_we,
  input  logic [$clog2(TAPS/GROUP)+GROUP-1:0] lut_addr,
  input  logic [LUT_W-1:0]                    lut_wdata,
  output logic                                lut_wr_err
);
  localparam int NG = TAPS / GROUP;
  localparam int AW = $clog2(NG) + GROUP;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_idx;
  logic [DATA_W-1:0]       x_q [TAPS];
  logic [DATA_W-1:0]       x_d [TAPS];
  logic signed [LUT_W-1:0] lut_q [2**AW];
  logic signed [LUT_W-1:0] rd_q [NG];
  logic signed [LUT_W-1:0] rd_d [NG];
  logic [GROUP-1:0]        grp_addr [NG];
  logic                    s1_vld_q, s1_vld_d, s1_first_q, s1_first_d;
  logic                    s2_vld_q, s2_vld_d, s2_first_q, s2_first_d;
  logic signed [ACC_W-1:0] sum_q, sum_d, acc_q, acc_d, shifted;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d, out_valid_q, out_valid_d;
  logic                    lut_wr_err_q, lut_wr_err_d, lut_wr;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    out_sat_d    = out_sat_q;
    out_valid_d  = out_valid_q;
    bit_idx      = BW'(DATA_W - 1) - cnt_q;
    s1_vld_d     = (state_q == RUN);
    s1_first_d   = (state_q == RUN) && (cnt_q == '0);
    s2_vld_d     = s1_vld_q;
    s2_first_d   = s1_first_q;
    sum_d        = '0;
    shifted      = acc_q >>> OUT_SHIFT;
    lut_wr       = lut_we && (state_q == IDLE) && !clear;
    lut_wr_err_d = lut_we && (state_q != IDLE) && !clear;

    // Stage 1: one LUT lookup per group addressed by bit j of that group's taps.
    for (int g = 0; g < NG; g++) begin
      grp_addr[g] = '0;
      for (int m = 0; m < GROUP; m++) grp_addr[g][m] = x_q[g*GROUP+m][bit_idx];
      rd_d[g] = lut_q[AW'(g << GROUP) | AW'(grp_addr[g])];
    end
    // Stage 2: sum of group partials; stage 3: MSB pass carries negative weight.
    for (int g = 0; g < NG; g++) sum_d = sum_d + ACC_W'(rd_q[g]);
    if (s2_vld_q) acc_d = s2_first_q ? (acc_q <<< 1) - sum_q : (acc_q <<< 1) + sum_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d[0] = in_data;
          for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == BW'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == BW'(1)) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          if (shifted > SAT_MAX) begin
            out_data_d = SAT_MAX[OUT_W-1:0];
            out_sat_d  = 1'b1;
          end else if (shifted < SAT_MIN) begin
            out_data_d = SAT_MIN[OUT_W-1:0];
            out_sat_d  = 1'b1;
          end else begin
            out_data_d = shifted[OUT_W-1:0];
            out_sat_d  = 1'b0;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // clear wins over every handshake and flushes the pipeline valids.
    if (clear) begin
      for (int k = 0; k < TAPS; k++) x_d[k] = '0;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_sat_d   = 1'b0;
      s1_vld_d    = 1'b0;
      s2_vld_d    = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      for (int g = 0; g < NG; g++) rd_q[g] <= '0;
      s1_vld_q     <= 1'b0;
      s1_first_q   <= 1'b0;
      s2_vld_q     <= 1'b0;
      s2_first_q   <= 1'b0;
      sum_q        <= '0;
      acc_q        <= '0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      lut_wr_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      rd_q         <= rd_d;
      s1_vld_q     <= s1_vld_d;
      s1_first_q   <= s1_first_d;
      s2_vld_q     <= s2_vld_d;
      s2_first_q   <= s2_first_d;
      sum_q        <= sum_d;
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
      out_sat_q    <= out_sat_d;
      out_valid_q  <= out_valid_d;
      lut_wr_err_q <= lut_wr_err_d;
    end
  end

  // LUT contents survive reset and clear; software owns them.
  always_ff @(posedge clk) begin
    if (lut_wr && !reset) lut_q[lut_addr] <= lut_wdata;
  end

  assign in_ready   = (state_q == IDLE) && !clear;
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  assign lut_wr_err = lut_wr_err_q;
endmodule

// File: tb/tb_da_fir_engine.sv
// Bench for da_fir_engine: a default instance and an OUT_W=8 instance driven in lockstep,
// checked against a direct-form convolution scoreboard.
module tb_da_fir_engine;
  logic        clk = 1'b0;
  logic        reset, clear, in_valid, out_ready, lut_we;
  logic [7:0]  in_data;
  logic [4:0]  lut_addr;
  logic [19:0] lut_wdata;
  logic        in_ready1, in_ready2, busy1, busy2, err1, err2;
  logic        out_valid1, out_valid2, out_sat1, out_sat2;
  logic [23:0] out_data1;
  logic [7:0]  out_data2;

  int n_cmp = 0;
  int n_bad = 0;
  int h[8];
  int mx[8];
  int qd1[$];
  int qd2[$];
  bit qs1[$];
  bit qs2[$];

  da_fir_engine dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_sat(out_sat1), .busy(busy1), .lut_we(lut_we), .lut_addr(lut_addr),
    .lut_wdata(lut_wdata), .lut_wr_err(err1));

  da_fir_engine #(.OUT_W(8)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_sat(out_sat2), .busy(busy2), .lut_we(lut_we), .lut_addr(lut_addr),
    .lut_wdata(lut_wdata), .lut_wr_err(err2));

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int k = 0; k < 8; k++) mx[k] = 0;
    qd1.delete(); qd2.delete(); qs1.delete(); qs2.delete();
  endfunction

  function automatic void model_push(input int s);
    int y;
    y = 0;
    for (int k = 7; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = s;
    for (int k = 0; k < 8; k++) y += h[k] * mx[k];
    if (y > 8388607) begin qd1.push_back(8388607); qs1.push_back(1'b1); end
    else if (y < -8388608) begin qd1.push_back(-8388608); qs1.push_back(1'b1); end
    else begin qd1.push_back(y); qs1.push_back(1'b0); end
    if (y > 127) begin qd2.push_back(127); qs2.push_back(1'b1); end
    else if (y < -128) begin qd2.push_back(-128); qs2.push_back(1'b1); end
    else begin qd2.push_back(y); qs2.push_back(1'b0); end
  endfunction

  task automatic pop_expect(output int e1, output bit es1, output int e2, output bit es2);
    e1 = -99999; es1 = 1'b0; e2 = -99999; es2 = 1'b0;
    if (qd1.size() > 0) begin e1 = qd1.pop_front(); es1 = qs1.pop_front(); end
    if (qd2.size() > 0) begin e2 = qd2.pop_front(); es2 = qs2.pop_front(); end
  endtask

  task automatic load_lut(input int mode);
    int v;
    for (int k = 0; k < 8; k++) h[k] = (mode == 0) ? k + 1 : 127;
    for (int g = 0; g < 2; g++) begin
      for (int a = 0; a < 16; a++) begin
        v = 0;
        for (int m = 0; m < 4; m++) if (((a >> m) & 1) == 1) v += h[g*4+m];
        lut_we = 1'b1; lut_addr = 5'(g*16 + a); lut_wdata = 20'(v);
        @(negedge clk);
      end
    end
    lut_we = 1'b0;
  endtask

  task automatic accept(input int s, output bit to);
    int n;
    n = 0; to = 1'b0;
    while (in_ready1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (in_ready1 !== 1'b1) begin to = 1'b1; return; end
    in_valid = 1'b1; in_data = 8'(s);
    @(negedge clk);
    in_valid = 1'b0;
    model_push(s);
  endtask

  task automatic collect(input bit hs, output int d1, output bit s1, output int d2, output bit s2,
                         output int lat, output bit to);
    lat = 0; to = 1'b0; d1 = 0; s1 = 1'b0; d2 = 0; s2 = 1'b0;
    while (out_valid1 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    if (out_valid1 !== 1'b1) begin to = 1'b1; model_clear(); return; end
    d1 = int'($signed(out_data1)); s1 = out_sat1;
    d2 = int'($signed(out_data2)); s2 = out_sat2;
    if (hs) begin out_ready = 1'b1; @(negedge clk); out_ready = 1'b0; end
  endtask

  task automatic xfer(input int s, output int d1, output bit s1, output int d2, output bit s2,
                      output int lat, output bit to);
    accept(s, to);
    if (to) return;
    collect(1'b1, d1, s1, d2, s2, lat, to);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready1 !== 1'b1 || in_ready2 !== 1'b1) begin n_bad++; $display("FAIL reset in_ready got %b/%b want 1", in_ready1, in_ready2); end
    n_cmp++; if (out_valid1 !== 1'b0) begin n_bad++; $display("FAIL reset out_valid got %b want 0", out_valid1); end
    n_cmp++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_bad++; $display("FAIL reset busy got %b/%b want 0", busy1, busy2); end
    n_cmp++; if (out_data1 !== 24'd0 || out_sat1 !== 1'b0) begin n_bad++; $display("FAIL reset out_data got %0d sat %b want 0/0", out_data1, out_sat1); end
    n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL reset lut_wr_err got %b want 0", err1); end
    reset = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_impulse();
    int exp_c[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0};
    int d1, d2, e1, e2, lat; bit s1, s2, es1, es2, to;
    for (int i = 0; i < 10; i++) begin
      xfer((i == 0) ? 1 : 0, d1, s1, d2, s2, lat, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL impulse[%0d] timeout", i); continue; end
      pop_expect(e1, es1, e2, es2);
      if (d1 !== exp_c[i] || s1 !== 1'b0) begin n_bad++; $display("FAIL impulse[%0d] got %0d sat %b want %0d sat 0", i, d1, s1, exp_c[i]); end
      n_cmp++; if (d2 !== e2 || s2 !== es2) begin n_bad++; $display("FAIL impulse8[%0d] got %0d sat %b want %0d sat %b", i, d2, s2, e2, es2); end
      if (i == 0) begin
        n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL latency got %0d want 11", lat); end
      end
    end
  endtask

  task automatic test_negative();
    int d1, d2, e1, e2, lat; bit s1, s2, es1, es2, to;
    for (int i = 0; i < 8; i++) begin
      xfer((i == 0) ? -128 : 0, d1, s1, d2, s2, lat, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL neg[%0d] timeout", i); continue; end
      pop_expect(e1, es1, e2, es2);
      if (d1 !== -128 * (i + 1) || s1 !== 1'b0) begin n_bad++; $display("FAIL neg[%0d] got %0d sat %b want %0d sat 0", i, d1, s1, -128 * (i + 1)); end
      n_cmp++; if (d2 !== e2 || s2 !== es2) begin n_bad++; $display("FAIL neg8[%0d] got %0d sat %b want %0d sat %b", i, d2, s2, e2, es2); end
    end
  endtask

  task automatic test_backpressure();
    int d1, d2, e1, e2, lat; bit s1, s2, es1, es2, to;
    logic [23:0] held;
    accept(3, to);
    if (!to) collect(1'b0, d1, s1, d2, s2, lat, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL backpressure timeout"); return; end
    pop_expect(e1, es1, e2, es2);
    if (d1 !== e1) begin n_bad++; $display("FAIL backpressure data got %0d want %0d", d1, e1); end
    held = out_data1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (out_data1 !== held || out_valid1 !== 1'b1) begin n_bad++; $display("FAIL hold[%0d] data %0d vld %b want %0d vld 1", i, out_data1, out_valid1, held); end
      n_cmp++; if (in_ready1 !== 1'b0) begin n_bad++; $display("FAIL hold[%0d] in_ready got %b want 0", i, in_ready1); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin n_bad++; $display("FAIL release vld %b rdy %b want 0/1", out_valid1, in_ready1); end
  endtask

  task automatic test_lut_protect();
    int d1, d2, e1, e2, lat; bit s1, s2, es1, es2, to;
    accept(1, to);
    repeat (2) @(negedge clk);
    lut_we = 1'b1; lut_addr = 5'd1; lut_wdata = 20'd999;
    @(negedge clk);
    lut_we = 1'b0;
    n_cmp++; if (err1 !== 1'b1 || err2 !== 1'b1) begin n_bad++; $display("FAIL lut_wr_err pulse got %b/%b want 1", err1, err2); end
    @(negedge clk);
    n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL lut_wr_err after got %b want 0", err1); end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        if (!to) collect(1'b1, d1, s1, d2, s2, lat, to);
      end else begin
        xfer((i == 1) ? 1 : 0, d1, s1, d2, s2, lat, to);
      end
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL lutprot[%0d] timeout", i); continue; end
      pop_expect(e1, es1, e2, es2);
      if (d1 !== e1 || s1 !== es1) begin n_bad++; $display("FAIL lutprot[%0d] got %0d want %0d", i, d1, e1); end
    end
  endtask

  task automatic test_abort(input bit use_reset);
    int d1, d2, lat; bit s1, s2, to, seen;
    accept(5, to);
    repeat (3) @(negedge clk);
    if (use_reset) reset = 1'b1; else clear = 1'b1;
    @(negedge clk);
    reset = 1'b0; clear = 1'b0;
    model_clear();
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (out_valid1 === 1'b1) seen = 1'b1; end
    n_cmp++; if (seen || busy1 !== 1'b0) begin n_bad++; $display("FAIL abort(rst=%b) out_valid seen %b busy %b want 0/0", use_reset, seen, busy1); end
    xfer(1, d1, s1, d2, s2, lat, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL abort(rst=%b) impulse timeout", use_reset); end
    else if (d1 !== 1 || s1 !== 1'b0) begin n_bad++; $display("FAIL abort(rst=%b) impulse got %0d want 1", use_reset, d1); end
    model_push(0); model_clear();
    for (int i = 0; i < 8; i++) begin
      xfer(0, d1, s1, d2, s2, lat, to);
      if (to) break;
    end
    model_clear();
  endtask

  task automatic test_saturation();
    int d1, d2, e1, e2, lat; bit s1, s2, es1, es2, to;
    int v;
    load_lut(1);
    for (int i = 0; i < 16; i++) begin
      v = (i < 8) ? 127 : -128;
      xfer(v, d1, s1, d2, s2, lat, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL sat[%0d] timeout", i); continue; end
      pop_expect(e1, es1, e2, es2);
      if (d1 !== e1 || s1 !== es1) begin n_bad++; $display("FAIL sat24[%0d] got %0d sat %b want %0d sat %b", i, d1, s1, e1, es1); end
      n_cmp++; if (d2 !== e2 || s2 !== es2) begin n_bad++; $display("FAIL sat8[%0d] got %0d sat %b want %0d sat %b", i, d2, s2, e2, es2); end
      if (i == 7) begin
        n_cmp++; if (d2 !== 127 || s2 !== 1'b1) begin n_bad++; $display("FAIL sat_pos got %0d sat %b want 127 sat 1", d2, s2); end
      end
      if (i == 15) begin
        n_cmp++; if (d2 !== -128 || s2 !== 1'b1) begin n_bad++; $display("FAIL sat_neg got %0d sat %b want -128 sat 1", d2, s2); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; lut_we = 1'b0;
    in_data = '0; lut_addr = '0; lut_wdata = '0;
    for (int k = 0; k < 8; k++) h[k] = 0;
    @(negedge clk);
    test_reset();
    load_lut(0);
    test_impulse();
    test_negative();
    test_backpressure();
    test_lut_protect();
    test_abort(1'b0);
    test_abort(1'b1);
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
